core_pipe_stage: RTL and testbench

- Generic, parametrised pipeline stage register for the RV64IM core. Successor to the fixed-width, always-enabled IF/ID latch.
- Carries an arbitrary payload (default: 64-bit PC concatenated with 32-bit instruction) using a valid/ready handshake.
- Includes a 2-entry skid buffer so that in_ready is fully registered, plus a synchronous flush for branch/exception kill.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/core_pipe_stage.sv | 97 +++++++++
 tb/tb_core_pipe_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/core_pipe_stage.sv
// core_pipe_stage: generic valid/ready pipeline register with a 2-entry skid
// buffer. The head entry (main) drives out_data; a second beat lands in the
// skid register when downstream stalls. in_ready comes straight from a flop so
// that out_ready never reaches the upstream stage combinationally.
module core_pipe_stage #(
  parameter int                 DATA_W = 96,
  parameter logic [DATA_W-1:0]  BUBBLE = DATA_W'({64'h0, 32'h00000013})
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;
  logic              acc;
  logic              fire;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready_q;
  assign fire      = out_valid & out_ready;

  // Occupancy is a direct decode of the state register.
  always_comb begin
    occupancy = 2'd0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // State machine plus storage; flush outranks any handshake in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      state      <= EMPTY;
      main_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (acc && fire) begin
            main_q <= in_data;
          end else if (acc) begin
            skid_q     <= in_data;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            main_q     <= skid_q;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          main_q     <= BUBBLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_pipe_stage.sv
// Testbench for core_pipe_stage: directed vector table on the default 96-bit
// instance, an asynchronous reset check, and random traffic on a 32-bit
// instance compared against a queue-based reference model.
module tb_core_pipe_stage;

  localparam logic [95:0] BUB96 = {64'h0, 32'h00000013};
  localparam logic [31:0] BUB32 = 32'hDEADBEEF;

  logic        clk;
  logic        rst;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [1:0]  occupancy;

  logic        flush32;
  logic        in_valid32;
  logic        in_ready32;
  logic [31:0] in_data32;
  logic        out_valid32;
  logic        out_ready32;
  logic [31:0] out_data32;
  logic [1:0]  occupancy32;

  int n_checks;
  int n_fail;

  core_pipe_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  core_pipe_stage #(.DATA_W(32), .BUBBLE(32'hDEADBEEF)) dut32 (
    .clk(clk), .rst(rst), .flush(flush32),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
    .occupancy(occupancy32)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [95:0] in_data;
    logic        out_ready;
    logic        exp_valid;
    logic        exp_ready;
    logic [1:0]  exp_occ;
    logic [95:0] exp_data;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic f, input logic v, input logic [95:0] d,
                              input logic r, input logic ev, input logic er,
                              input logic [1:0] eo, input logic [95:0] ed);
    vec_t t;
    t.flush = f; t.in_valid = v; t.in_data = d; t.out_ready = r;
    t.exp_valid = ev; t.exp_ready = er; t.exp_occ = eo; t.exp_data = ed;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] actual,
                             input logic [95:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one vector at the falling edge, then check the state after the rising edge.
  task automatic applyStimulus(input vec_t t, input int idx);
    @(negedge clk);
    flush     = t.flush;
    in_valid  = t.in_valid;
    in_data   = t.in_data;
    out_ready = t.out_ready;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d out_valid", idx), {95'h0, out_valid}, {95'h0, t.exp_valid});
    checkOutput($sformatf("vec%0d in_ready", idx), {95'h0, in_ready}, {95'h0, t.exp_ready});
    checkOutput($sformatf("vec%0d occupancy", idx), {94'h0, occupancy}, {94'h0, t.exp_occ});
    checkOutput($sformatf("vec%0d out_data", idx), out_data, t.exp_data);
  endtask

  logic [31:0] model_q[$];
  logic [31:0] model_last;
  logic [31:0] next_seq;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    flush32 = 0; in_valid32 = 0; in_data32 = '0; out_ready32 = 0;

    //            flush vld data        ordy  ov rdy occ data
    vecs[0]  = mk(0, 1, 96'h1,    1,  1, 1, 2'd1, 96'h1);
    vecs[1]  = mk(0, 1, 96'h2,    1,  1, 1, 2'd1, 96'h2);
    vecs[2]  = mk(0, 1, 96'h3,    1,  1, 1, 2'd1, 96'h3);
    vecs[3]  = mk(0, 1, 96'h4,    1,  1, 1, 2'd1, 96'h4);
    vecs[4]  = mk(0, 0, 96'h0,    1,  0, 1, 2'd0, 96'h4);
    vecs[5]  = mk(0, 1, 96'hAAAA, 0,  1, 1, 2'd1, 96'hAAAA);
    vecs[6]  = mk(0, 1, 96'hBBBB, 0,  1, 0, 2'd2, 96'hAAAA);
    vecs[7]  = mk(0, 1, 96'hCCCC, 0,  1, 0, 2'd2, 96'hAAAA);
    vecs[8]  = mk(0, 0, 96'h0,    1,  1, 1, 2'd1, 96'hBBBB);
    vecs[9]  = mk(0, 0, 96'h0,    1,  0, 1, 2'd0, 96'hBBBB);
    vecs[10] = mk(0, 1, 96'h5151, 0,  1, 1, 2'd1, 96'h5151);
    vecs[11] = mk(0, 1, 96'h5252, 1,  1, 1, 2'd1, 96'h5252);
    vecs[12] = mk(0, 1, 96'hAAAA, 0,  1, 0, 2'd2, 96'h5252);
    vecs[13] = mk(1, 1, 96'hCCCC, 0,  0, 1, 2'd0, BUB96);
    vecs[14] = mk(0, 0, 96'h0,    1,  0, 1, 2'd0, BUB96);
    vecs[15] = mk(0, 1, 96'hD0D0, 1,  1, 1, 2'd1, 96'hD0D0);
    vecs[16] = mk(1, 1, 96'hE0E0, 1,  0, 1, 2'd0, BUB96);
    vecs[17] = mk(0, 0, 96'h0,    0,  0, 1, 2'd0, BUB96);

    #12;
    checkOutput("reset out_data96", out_data, BUB96);
    checkOutput("reset out_data32", {64'h0, out_data32}, {64'h0, BUB32});
    checkOutput("reset in_ready", {95'h0, in_ready}, 96'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) applyStimulus(vecs[i], i);

    // Fill to FULL, then raise reset partway through a cycle.
    applyStimulus(mk(0, 1, 96'hA1, 0, 1, 1, 2'd1, 96'hA1), 100);
    applyStimulus(mk(0, 1, 96'hB1, 0, 1, 0, 2'd2, 96'hA1), 101);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst out_valid", {95'h0, out_valid}, 96'h0);
    checkOutput("async rst in_ready", {95'h0, in_ready}, 96'h1);
    checkOutput("async rst occupancy", {94'h0, occupancy}, 96'h0);
    checkOutput("async rst out_data", out_data, BUB96);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 96'hF00D; out_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post-rst accept occ", {94'h0, occupancy}, 96'h1);
    checkOutput("post-rst accept data", out_data, 96'hF00D);
    @(negedge clk);
    in_valid = 1'b0;

    // Random traffic on the 32-bit instance against a FIFO model.
    model_q.delete();
    model_last = BUB32;
    next_seq = 32'h100;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic f, v, r, acc_m, fire_m;
      @(negedge clk);
      checkOutput("rnd out_valid", {95'h0, out_valid32}, {95'h0, model_q.size() > 0});
      checkOutput("rnd in_ready", {95'h0, in_ready32}, {95'h0, model_q.size() < 2});
      checkOutput("rnd occupancy", {94'h0, occupancy32}, 96'(model_q.size()));
      checkOutput("rnd out_data", {64'h0, out_data32},
                  {64'h0, (model_q.size() > 0) ? model_q[0] : model_last});
      f = ($urandom_range(0, 31) == 0);
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) != 0;
      flush32 = f; in_valid32 = v; out_ready32 = r; in_data32 = next_seq;
      acc_m  = v && (model_q.size() < 2);
      fire_m = r && (model_q.size() > 0);
      if (f) begin
        model_q.delete();
        model_last = BUB32;
      end else begin
        if (fire_m) void'(model_q.pop_front());
        if (acc_m) model_q.push_back(next_seq);
        if (model_q.size() > 0) model_last = model_q[0];
      end
      if (acc_m) next_seq = next_seq + 32'd1;
    end
    @(negedge clk);
    flush32 = 0; in_valid32 = 0; out_ready32 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
